spi_sclk_engine: RTL and testbench

Parametrised SPI serial-clock engine for the APB SPI master core: successor to the free-running baud rate generator. Generates SCLK from PCLK using the (SPPR+1)·2^(SPR+1) divisor, runs a bounded frame of a programmable bit count, and produces per-bit sample/shift strobes for the shift register. A start/busy/done handshake with the control FSM is included, as is wait-mode stall and abort. Sits between the APB register block (configuration) and the MOSI/MISO shift logic.

---
 rtl/spi_sclk_engine.sv | 187 ++++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: divides PCLK by (sppr+1)<<(spr+1), runs a frame of
// len bits, and emits registered sample/shift strobes aligned with SCLK edges.
module spi_sclk_engine #(
  parameter int unsigned SPPR_W = 3,
  parameter int unsigned SPR_W  = 3,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned BIT_W  = 5
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [1:0]                        spi_mode,
  input  logic                              spiswai,
  input  logic                              start,
  input  logic [BIT_W-1:0]                  len,
  input  logic [SPPR_W-1:0]                 sppr,
  input  logic [SPR_W-1:0]                  spr,
  input  logic                              cpol,
  input  logic                              cphase,
  output logic                              sclk,
  output logic                              sample_stb,
  output logic                              shift_stb,
  output logic                              busy,
  output logic                              done,
  output logic [SPPR_W+(1<<SPR_W)-1:0]      baud_div
);

  localparam int unsigned BD_W = SPPR_W + (1 << SPR_W);
  localparam int unsigned N_W  = BIT_W + 1;
  localparam int unsigned K_W  = BIT_W + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TAIL} state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_h, w_h_nx;
  logic [K_W-1:0]   r_k, w_k_nx;
  logic [N_W-1:0]   r_n, w_n_nx;
  logic             r_cphase, w_cphase_nx;
  logic             r_sclk, w_sclk_nx;
  logic             r_sample, w_sample_nx;
  logic             r_shift, w_shift_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;

  logic             w_runnable;
  logic             w_abort;
  logic [CNT_W-1:0] w_h_live;
  logic [N_W-1:0]   w_n_live;
  logic [SPR_W:0]   w_spr_p1;
  logic [K_W-1:0]   w_k_new;

  logic             w_count;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_h_cur;
  logic [N_W-1:0]   w_n_cur;
  logic             w_cph_cur;
  logic             w_sclk_cur;
  logic             w_edge_lead;

  assign w_runnable = (spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai);
  assign w_abort    = spi_mode[1];
  assign w_h_live   = (CNT_W'(sppr) + CNT_W'(1)) << spr;
  assign w_n_live   = (len == '0) ? (N_W'(1) << BIT_W) : N_W'(len);
  assign w_spr_p1   = {1'b0, spr} + (SPR_W+1)'(1);
  assign baud_div   = (BD_W'(sppr) + BD_W'(1)) << w_spr_p1;
  assign w_k_new    = r_k + K_W'(1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_h      <= '0;
      r_k      <= '0;
      r_n      <= '0;
      r_cphase <= 1'b0;
      r_sclk   <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_h      <= w_h_nx;
      r_k      <= w_k_nx;
      r_n      <= w_n_nx;
      r_cphase <= w_cphase_nx;
      r_sclk   <= w_sclk_nx;
      r_sample <= w_sample_nx;
      r_shift  <= w_shift_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_h_nx      = r_h;
    w_k_nx      = r_k;
    w_n_nx      = r_n;
    w_cphase_nx = r_cphase;
    w_sclk_nx   = r_sclk;
    w_sample_nx = 1'b0;
    w_shift_nx  = 1'b0;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_count     = 1'b0;
    w_cnt_cur   = r_cnt;
    w_h_cur     = r_h;
    w_n_cur     = r_n;
    w_cph_cur   = r_cphase;
    w_sclk_cur  = r_sclk;
    w_edge_lead = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_sclk_nx = cpol;
        w_cnt_nx  = '0;
        w_k_nx    = '0;
        if (r_busy) begin
          w_busy_nx = 1'b0;
        end else if (start && w_runnable) begin
          w_state_nx  = ST_RUN;
          w_busy_nx   = 1'b1;
          w_h_nx      = w_h_live;
          w_n_nx      = w_n_live;
          w_cphase_nx = cphase;
          // The start cycle already counts toward the first half period,
          // so edge k lands exactly k*H cycles after start is sampled.
          w_count     = 1'b1;
          w_cnt_cur   = '0;
          w_h_cur     = w_h_live;
          w_n_cur     = w_n_live;
          w_cph_cur   = cphase;
          w_sclk_cur  = cpol;
        end
      end
      ST_RUN, ST_TAIL: begin
        if (w_abort) begin
          w_state_nx = ST_IDLE;
          w_sclk_nx  = cpol;
          w_busy_nx  = 1'b0;
          w_cnt_nx   = '0;
          w_k_nx     = '0;
        end else if (w_runnable) begin
          if (r_state == ST_RUN) begin
            w_count = 1'b1;
          end else if (r_cnt == r_h - CNT_W'(1)) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_done_nx  = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_count) begin
      if (w_cnt_cur == w_h_cur - CNT_W'(1)) begin
        w_cnt_nx    = '0;
        w_sclk_nx   = ~w_sclk_cur;
        w_k_nx      = w_k_new;
        w_edge_lead = w_k_new[0];
        if (w_cph_cur) begin
          w_shift_nx  = w_edge_lead;
          w_sample_nx = !w_edge_lead;
        end else begin
          w_sample_nx = w_edge_lead;
          w_shift_nx  = !w_edge_lead && (w_k_new != {w_n_cur, 1'b0});
        end
        if (w_k_new == {w_n_cur, 1'b0}) w_state_nx = ST_TAIL;
      end else begin
        w_cnt_nx = w_cnt_cur + CNT_W'(1);
      end
    end
  end

  assign sclk       = r_sclk;
  assign sample_stb = r_sample;
  assign shift_stb  = r_shift;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: directed frames plus random traffic, all checked
// against an elapsed-cycle arithmetic model of the SCLK/strobe timeline.
module tb_spi_sclk_engine;

  localparam int unsigned SPPR_W = 3;
  localparam int unsigned SPR_W  = 3;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned BD_W   = SPPR_W + (1 << SPR_W);

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [1:0]        spi_mode = 2'b00;
  logic              spiswai = 1'b0;
  logic              start = 1'b0;
  logic [BIT_W-1:0]  len = '0;
  logic [SPPR_W-1:0] sppr = '0;
  logic [SPR_W-1:0]  spr = '0;
  logic              cpol = 1'b0;
  logic              cphase = 1'b0;
  logic              sclk, sample_stb, shift_stb, busy, done;
  logic [BD_W-1:0]   baud_div;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // model state
  bit m_active = 1'b0;
  int m_e = 0, m_h = 1, m_n = 1;
  bit m_cpol = 1'b0, m_cph = 1'b0;
  bit e_sclk = 1'b0, e_sample = 1'b0, e_shift = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  spi_sclk_engine #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .CNT_W(CNT_W), .BIT_W(BIT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .spi_mode(spi_mode), .spiswai(spiswai), .start(start),
    .len(len), .sppr(sppr), .spr(spr), .cpol(cpol), .cphase(cphase),
    .sclk(sclk), .sample_stb(sample_stb), .shift_stb(shift_stb), .busy(busy), .done(done),
    .baud_div(baud_div)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint exp_baud();
    longint v;
    v = (longint'(sppr) + 1) * (longint'(1) << (int'(spr) + 1));
    return v % (longint'(1) << BD_W);
  endfunction

  // Edge k of the frame falls after k*H counted cycles; edge 2N+1 marks done.
  task automatic model_edge();
    int k;
    if (m_e % m_h == 0) begin
      k = m_e / m_h;
      if (k <= 2 * m_n) begin
        e_sclk = m_cpol ^ k[0];
        if (m_cph) begin
          e_shift  = k[0];
          e_sample = !k[0];
        end else begin
          e_sample = k[0];
          e_shift  = !k[0] && (k != 2 * m_n);
        end
      end else begin
        e_done   = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    bit run_ok;
    run_ok   = (spi_mode == 2'b00) || (spi_mode == 2'b01 && !spiswai);
    e_sample = 1'b0;
    e_shift  = 1'b0;
    e_done   = 1'b0;
    if (PRESET) begin
      m_active = 1'b0;
      e_sclk   = 1'b0;
      e_busy   = 1'b0;
    end else if (m_active) begin
      if (spi_mode[1]) begin
        m_active = 1'b0;
        e_busy   = 1'b0;
        e_sclk   = cpol;
      end else if (run_ok) begin
        m_e++;
        model_edge();
      end
    end else begin
      e_sclk = cpol;
      if (e_busy) begin
        e_busy = 1'b0;
      end else if (start && run_ok) begin
        m_h      = (int'(sppr) + 1) * (1 << int'(spr));
        m_n      = (len == 0) ? (1 << BIT_W) : int'(len);
        m_cpol   = cpol;
        m_cph    = cphase;
        m_e      = 1;
        m_active = 1'b1;
        e_busy   = 1'b1;
        model_edge();
      end
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    model_step();
    #1;
    chk("sclk",       64'(sclk),       64'(e_sclk));
    chk("sample_stb", 64'(sample_stb), 64'(e_sample));
    chk("shift_stb",  64'(shift_stb),  64'(e_shift));
    chk("busy",       64'(busy),       64'(e_busy));
    chk("done",       64'(done),       64'(e_done));
    chk("baud_div",   64'(baud_div),   64'(exp_baud()));
  endtask

  task automatic frame(input string tag, input int exp_lat, input int exp_samp, input int exp_shf,
                       input int stall_at, input int stall_len, input int abort_at, input bit extra_start);
    int lat, ns, nsh, nb, nd, total;
    bit frozen;
    lat = 0; ns = 0; nsh = 0; nb = 0; nd = 0; frozen = 1'b0;
    total = exp_lat + stall_len;
    start = 1'b1;
    for (int i = 1; i <= total + 6; i++) begin
      tick();
      if (sample_stb) ns++;
      if (shift_stb)  nsh++;
      if (busy)       nb++;
      if (done) begin
        nd++;
        if (lat == 0) lat = i;
      end
      if (stall_at != 0 && i == stall_at) frozen = sclk;
      if (stall_at != 0 && i > stall_at && i <= stall_at + stall_len) begin
        chk({tag, "_stall_sclk"},  64'(sclk), 64'(frozen));
        chk({tag, "_stall_strobe"}, 64'({sample_stb, shift_stb}), 64'(0));
      end
      if (abort_at != 0 && i == abort_at + 1) begin
        chk({tag, "_abort_busy"}, 64'(busy), 64'(0));
        chk({tag, "_abort_sclk"}, 64'(sclk), 64'(cpol));
      end
      start    = extra_start && (i == 20 || i == total);
      spi_mode = 2'b00;
      spiswai  = 1'b0;
      if (stall_at != 0 && i >= stall_at && i < stall_at + stall_len) begin
        spi_mode = 2'b01;
        spiswai  = 1'b1;
      end
      if (abort_at != 0 && i == abort_at) spi_mode = 2'b10;
    end
    start = 1'b0;
    if (abort_at == 0) begin
      chk({tag, "_done_lat"},  64'(lat), 64'(total));
      chk({tag, "_n_sample"},  64'(ns),  64'(exp_samp));
      chk({tag, "_n_shift"},   64'(nsh), 64'(exp_shf));
      chk({tag, "_busy_cyc"},  64'(nb),  64'(total));
      chk({tag, "_n_done"},    64'(nd),  64'(1));
    end else begin
      chk({tag, "_n_done"},    64'(nd),  64'(0));
    end
  endtask

  initial begin
    // reset with cpol=1 so a reset sclk of 0 is distinguishable
    PRESET = 1'b1;
    cpol   = 1'b1;
    repeat (3) tick();
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    PRESET = 1'b0;
    tick();
    chk("post_rst_sclk_cpol", 64'(sclk), 64'(1));

    sppr = 3'd2; spr = 3'd1; len = 5'd8; cpol = 1'b0; cphase = 1'b0;
    tick();
    chk("baud12", 64'(baud_div), 64'(12));
    frame("f1_h6_n8", 102, 8, 7, 0, 0, 0, 1'b1);

    sppr = 3'd0; spr = 3'd0; cpol = 1'b1; cphase = 1'b1; len = 5'd3;
    repeat (2) tick();
    chk("idle_cpol1", 64'(sclk), 64'(1));
    frame("f2_h1_n3", 7, 3, 3, 0, 0, 0, 1'b0);

    cpol = 1'b0; cphase = 1'b0; len = 5'd0;
    tick();
    frame("f3_h1_n32", 65, 32, 31, 0, 0, 0, 1'b0);

    sppr = 3'd2; spr = 3'd1; len = 5'd8;
    tick();
    frame("f4_stall", 102, 8, 7, 20, 10, 0, 1'b0);
    tick();
    frame("f5_abort", 102, 0, 0, 0, 0, 40, 1'b0);

    // PRESET at edge 5 of a 16-bit frame with H=2
    sppr = 3'd1; spr = 3'd0; len = 5'd16; cpol = 1'b1; cphase = 1'b0;
    tick();
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 1'b0;
    end
    PRESET = 1'b1;
    tick();
    chk("prst_sclk",  64'(sclk), 64'(0));
    chk("prst_strb",  64'({sample_stb, shift_stb}), 64'(0));
    chk("prst_busy",  64'(busy), 64'(0));
    chk("prst_done",  64'(done), 64'(0));
    PRESET = 1'b0;
    tick();
    frame("f6_after_rst", 66, 16, 15, 0, 0, 0, 1'b0);

    // random traffic
    for (int i = 0; i < 8000; i++) begin
      int r;
      start = ($urandom_range(0, 999) < 15);
      r = int'($urandom_range(0, 999));
      if (r < 940)      spi_mode = 2'b00;
      else if (r < 999) spi_mode = 2'b01;
      else              spi_mode = {1'b1, 1'($urandom_range(0, 1))};
      spiswai = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        sppr   = SPPR_W'($urandom_range(0, 3));
        spr    = SPR_W'($urandom_range(0, 2));
        len    = BIT_W'($urandom);
        cpol   = 1'($urandom_range(0, 1));
        cphase = 1'($urandom_range(0, 1));
      end
      PRESET = ($urandom_range(0, 2999) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
